// File: rtl/ysyx_201979054_mem_arbiter.sv
// rtl/ysyx_201979054_mem_arbiter.sv - two-client (I-cache/D-cache) arbiter and line buffer in front of the AXI4 master
//
// Purpose: grants one cache request at a time, converts it into a single
// request on the AXI4 master's CPU-side interface with stable burst
// attributes, assembles/serialises 64-bit beats and returns the result to
// the owning client with a one-cycle valid pulse.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   i_ic_req/i_ic_addr          I-cache line refill request (level)
//   o_ic_line/o_ic_valid        I-cache refilled line, completion pulse
//   i_dc_req/we/uncached/addr   D-cache request (level) and its kind
//   i_dc_wline/wdata/strb/size  D-cache write line, uncached data/strobe/size
//   o_dc_rline/rdata/valid      D-cache refilled line, uncached beat, pulse
//   o_read_req/o_write_req      one-cycle request pulses to the AXI4 master
//   o_addr/o_axi_len/size/burst/strb  held transaction attributes
//   o_write_data                current write beat
//   i_read_data/i_axi_handshake/i_axi_done  beat data, beat strobe, completion

module ysyx_201979054_mem_arbiter #(
    parameter int LINE_BEATS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     i_ic_req,
    input  logic [ADDR_W-1:0]        i_ic_addr,
    output logic [64*LINE_BEATS-1:0] o_ic_line,
    output logic                     o_ic_valid,
    input  logic                     i_dc_req,
    input  logic                     i_dc_we,
    input  logic                     i_dc_uncached,
    input  logic [ADDR_W-1:0]        i_dc_addr,
    input  logic [64*LINE_BEATS-1:0] i_dc_wline,
    input  logic [63:0]              i_dc_wdata,
    input  logic [7:0]               i_dc_strb,
    input  logic [2:0]               i_dc_size,
    output logic [64*LINE_BEATS-1:0] o_dc_rline,
    output logic [63:0]              o_dc_rdata,
    output logic                     o_dc_valid,
    output logic                     o_write_req,
    output logic                     o_read_req,
    output logic [ADDR_W-1:0]        o_addr,
    output logic [63:0]              o_write_data,
    output logic [7:0]               o_axi_len,
    output logic [2:0]               o_axi_size,
    output logic [1:0]               o_axi_burst,
    output logic [7:0]               o_axi_strb,
    input  logic [63:0]              i_read_data,
    input  logic                     i_axi_done,
    input  logic                     i_axi_handshake
);

    localparam int LW     = 64 * LINE_BEATS;
    localparam int OFF_W  = $clog2(8 * LINE_BEATS);
    localparam int BEAT_W = $clog2(LINE_BEATS);
    localparam int CNT_W  = BEAT_W + 1;

    localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    localparam logic [7:0]        LINE_LEN  = 8'(LINE_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_XFER  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_owner_dc;
    logic              r_last_dc;
    logic              r_we;
    logic              r_unc;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic [7:0]        r_strb;
    logic [63:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic [LW-1:0]     r_line;
    logic [63:0]       r_rdata;

    logic              w_any_req;
    logic              w_grant_dc;
    logic              w_cnt_sat;
    logic [BEAT_W-1:0] w_idx;
    logic [BEAT_W-1:0] w_widx;

    // D-cache has priority, but yields to a waiting I-cache right after it
    // was served, so contention alternates D, I, D, I ...
    assign w_any_req  = i_ic_req | i_dc_req;
    assign w_grant_dc = i_dc_req & ~(i_ic_req & r_last_dc);

    // The counter has one extra bit; once it reaches LINE_BEATS it stops and
    // further handshakes no longer touch the buffer.
    assign w_cnt_sat = r_cnt[BEAT_W];
    assign w_idx     = r_cnt[BEAT_W-1:0];
    assign w_widx    = w_cnt_sat ? LAST_BEAT : w_idx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)  w_next = S_ISSUE;
            S_ISSUE: w_next = S_XFER;
            S_XFER:  if (i_axi_done) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= S_IDLE;
            r_owner_dc <= 1'b0;
            r_last_dc  <= 1'b0;
            r_we       <= 1'b0;
            r_unc      <= 1'b0;
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_strb     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_line     <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next;

            if (r_state == S_IDLE && w_any_req) begin
                r_owner_dc <= w_grant_dc;
                r_last_dc  <= w_grant_dc;
                r_we       <= w_grant_dc & i_dc_we;
                r_unc      <= w_grant_dc & i_dc_uncached;
                r_wdata    <= i_dc_wdata;
                r_cnt      <= '0;
                r_burst    <= 2'b01;
                if (w_grant_dc && i_dc_uncached) begin
                    r_addr <= i_dc_addr;
                    r_len  <= 8'd0;
                    r_size <= i_dc_size;
                    r_strb <= i_dc_strb;
                end else begin
                    r_addr <= (w_grant_dc ? i_dc_addr : i_ic_addr) & LINE_MASK;
                    r_len  <= LINE_LEN;
                    r_size <= 3'b011;
                    r_strb <= 8'hFF;
                end
            end

            if (r_state == S_XFER && i_axi_handshake) begin
                if (!w_cnt_sat) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                if (!r_we) begin
                    if (r_unc) begin
                        r_rdata <= i_read_data;
                    end else if (!w_cnt_sat) begin
                        r_line[{w_idx, 6'd0} +: 64] <= i_read_data;
                    end
                end
            end
        end
    end

    // Write beats are taken live from the client, which holds its line
    // until it sees valid.
    always_comb begin
        o_write_data = '0;
        if ((r_state == S_ISSUE || r_state == S_XFER) && r_we) begin
            o_write_data = r_unc ? r_wdata : i_dc_wline[{w_widx, 6'd0} +: 64];
        end
    end

    assign o_read_req  = (r_state == S_ISSUE) && !r_we;
    assign o_write_req = (r_state == S_ISSUE) &&  r_we;
    assign o_ic_valid  = (r_state == S_RESP)  && !r_owner_dc;
    assign o_dc_valid  = (r_state == S_RESP)  &&  r_owner_dc;

    assign o_addr      = r_addr;
    assign o_axi_len   = r_len;
    assign o_axi_size  = r_size;
    assign o_axi_burst = r_burst;
    assign o_axi_strb  = r_strb;

    assign o_ic_line   = r_line;
    assign o_dc_rline  = r_line;
    assign o_dc_rdata  = r_rdata;

endmodule

// File: tb/tb_ysyx_201979054_mem_arbiter.sv
// tb/tb_ysyx_201979054_mem_arbiter.sv - scoreboard testbench for ysyx_201979054_mem_arbiter

module tb_ysyx_201979054_mem_arbiter;

    localparam int LB = 4;
    localparam int LW = 64 * LB;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          i_ic_req;
    logic [31:0]   i_ic_addr;
    logic [LW-1:0] o_ic_line;
    logic          o_ic_valid;
    logic          i_dc_req;
    logic          i_dc_we;
    logic          i_dc_uncached;
    logic [31:0]   i_dc_addr;
    logic [LW-1:0] i_dc_wline;
    logic [63:0]   i_dc_wdata;
    logic [7:0]    i_dc_strb;
    logic [2:0]    i_dc_size;
    logic [LW-1:0] o_dc_rline;
    logic [63:0]   o_dc_rdata;
    logic          o_dc_valid;
    logic          o_write_req;
    logic          o_read_req;
    logic [31:0]   o_addr;
    logic [63:0]   o_write_data;
    logic [7:0]    o_axi_len;
    logic [2:0]    o_axi_size;
    logic [1:0]    o_axi_burst;
    logic [7:0]    o_axi_strb;
    logic [63:0]   i_read_data;
    logic          i_axi_done;
    logic          i_axi_handshake;

    ysyx_201979054_mem_arbiter #(.LINE_BEATS(LB), .ADDR_W(32)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .i_ic_req        (i_ic_req),
        .i_ic_addr       (i_ic_addr),
        .o_ic_line       (o_ic_line),
        .o_ic_valid      (o_ic_valid),
        .i_dc_req        (i_dc_req),
        .i_dc_we         (i_dc_we),
        .i_dc_uncached   (i_dc_uncached),
        .i_dc_addr       (i_dc_addr),
        .i_dc_wline      (i_dc_wline),
        .i_dc_wdata      (i_dc_wdata),
        .i_dc_strb       (i_dc_strb),
        .i_dc_size       (i_dc_size),
        .o_dc_rline      (o_dc_rline),
        .o_dc_rdata      (o_dc_rdata),
        .o_dc_valid      (o_dc_valid),
        .o_write_req     (o_write_req),
        .o_read_req      (o_read_req),
        .o_addr          (o_addr),
        .o_write_data    (o_write_data),
        .o_axi_len       (o_axi_len),
        .o_axi_size      (o_axi_size),
        .o_axi_burst     (o_axi_burst),
        .o_axi_strb      (o_axi_strb),
        .i_read_data     (i_read_data),
        .i_axi_done      (i_axi_done),
        .i_axi_handshake (i_axi_handshake)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          dc;
        logic [LW-1:0] line;
        logic [63:0]   rdata;
    } exp_t;

    exp_t          sb[$];
    logic [LW-1:0] exp_line;
    logic [63:0]   exp_rdata;
    int            checks   = 0;
    int            failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Plays the AXI4 master side: waits for the request pulse, checks the
    // attributes, transfers nbeats beats (seed*(k+1)) and signals done.
    task automatic serve(input logic dc, input logic we, input logic unc,
                         input logic [31:0] eaddr, input logic [7:0] elen,
                         input logic [2:0] esize, input logic [7:0] estrb,
                         input int nbeats, input int stall, input logic [63:0] seed);
        int          n;
        logic [63:0] d;
        exp_t        e;
        n = 0;
        while (!(o_read_req || o_write_req) && n < 10) begin
            tick();
            n++;
        end
        check("req_seen", {o_write_req, o_read_req}, we ? 2'b10 : 2'b01);
        check("addr", o_addr, eaddr);
        check("len", o_axi_len, elen);
        check("size", o_axi_size, esize);
        check("burst", o_axi_burst, 2'b01);
        check("strb", o_axi_strb, estrb);
        tick();
        check("req_one_cycle", {o_write_req, o_read_req}, 2'b00);
        for (int k = 0; k < nbeats; k++) begin
            for (int s = 0; s < stall; s++) tick();
            d = seed * 64'(k + 1);
            if (we) begin
                check("wdata", o_write_data,
                      unc ? i_dc_wdata : i_dc_wline[64*((k < LB) ? k : LB-1) +: 64]);
            end
            i_read_data     = d;
            i_axi_handshake = 1'b1;
            tick();
            i_axi_handshake = 1'b0;
            if (!we) begin
                if (unc) exp_rdata = d;
                else if (k < LB) exp_line[64*k +: 64] = d;
            end
        end
        check("addr_held", o_addr, eaddr);
        e.dc    = dc;
        e.line  = exp_line;
        e.rdata = exp_rdata;
        sb.push_back(e);
        i_axi_done = 1'b1;
        tick();
        i_axi_done = 1'b0;
    endtask

    // Pops the scoreboard on the completion pulse and drops the owner's request.
    task automatic wait_valid();
        int   n;
        exp_t e;
        n = 0;
        while (!(o_ic_valid || o_dc_valid) && n < 4) begin
            tick();
            n++;
        end
        check("valid_latency", n, 0);
        check("sb_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("valid_owner", {o_ic_valid, o_dc_valid}, e.dc ? 2'b01 : 2'b10);
            if (e.dc) begin
                check("dc_rline", o_dc_rline, e.line);
                check("dc_rdata", o_dc_rdata, e.rdata);
                i_dc_req = 1'b0;
            end else begin
                check("ic_line", o_ic_line, e.line);
                i_ic_req = 1'b0;
            end
        end
        tick();
        check("valid_one_cycle", {o_ic_valid, o_dc_valid}, 2'b00);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        arst_n          = 1'b0;
        i_ic_req        = 1'b0;
        i_ic_addr       = '0;
        i_dc_req        = 1'b0;
        i_dc_we         = 1'b0;
        i_dc_uncached   = 1'b0;
        i_dc_addr       = '0;
        i_dc_wline      = {64'hD4D4_0000_0000_0004, 64'hC3C3_0000_0000_0003,
                           64'hB2B2_0000_0000_0002, 64'hA1A1_0000_0000_0001};
        i_dc_wdata      = 64'h0;
        i_dc_strb       = 8'h0;
        i_dc_size       = 3'd0;
        i_read_data     = '0;
        i_axi_done      = 1'b0;
        i_axi_handshake = 1'b0;
        exp_line        = '0;
        exp_rdata       = '0;

        // Reset state
        tick();
        tick();
        check("rst_valids", {o_ic_valid, o_dc_valid, o_read_req, o_write_req}, 4'b0);
        check("rst_attrs", {o_addr, o_axi_len, o_axi_size, o_axi_burst, o_axi_strb}, '0);
        check("rst_wdata", o_write_data, 64'h0);
        check("rst_line", o_ic_line, '0);
        check("rst_rdata", o_dc_rdata, 64'h0);
        arst_n = 1'b1;
        tick();

        // I-cache refill, unaligned address
        i_ic_addr = 32'h8000_0014;
        i_ic_req  = 1'b1;
        serve(1'b0, 1'b0, 1'b0, 32'h8000_0000, 8'd3, 3'd3, 8'hFF, 4, 0, 64'h11);
        wait_valid();
        check("ic_line_exact", o_ic_line, {64'h44, 64'h33, 64'h22, 64'h11});
        tick();
        check("no_regrant_ic", {o_read_req, o_write_req}, 2'b00);

        // D-cache line writeback with stalls between handshakes
        i_dc_addr     = 32'h8000_1000;
        i_dc_we       = 1'b1;
        i_dc_uncached = 1'b0;
        i_dc_req      = 1'b1;
        serve(1'b1, 1'b1, 1'b0, 32'h8000_1000, 8'd3, 3'd3, 8'hFF, 4, 2, 64'h99);
        wait_valid();
        i_dc_we = 1'b0;
        tick();
        check("no_regrant_dc", {o_read_req, o_write_req}, 2'b00);

        // Uncached read, size 2, strobe passes through
        i_dc_addr     = 32'h1000_0004;
        i_dc_uncached = 1'b1;
        i_dc_size     = 3'd2;
        i_dc_strb     = 8'h0F;
        i_dc_req      = 1'b1;
        serve(1'b1, 1'b0, 1'b1, 32'h1000_0004, 8'd0, 3'd2, 8'h0F, 1, 0, 64'hDEAD_BEEF);
        wait_valid();
        check("unc_rdata", o_dc_rdata, 64'hDEAD_BEEF);
        i_dc_uncached = 1'b0;
        tick();

        // Reset asserted during beat 2 of a refill
        i_ic_addr = 32'h8000_0040;
        i_ic_req  = 1'b1;
        tick();
        check("rst_mid_req", o_read_req, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            i_read_data     = 64'h700 + 64'(k);
            i_axi_handshake = 1'b1;
            tick();
        end
        i_read_data = 64'h702;
        arst_n      = 1'b0;
        #1;
        check("rst_mid_outs", {o_ic_valid, o_dc_valid, o_read_req, o_write_req}, 4'b0);
        check("rst_mid_attrs", {o_addr, o_axi_len, o_axi_size, o_axi_burst, o_axi_strb}, '0);
        check("rst_mid_line", o_ic_line, '0);
        tick();
        i_axi_handshake = 1'b0;
        check("rst_hold_valid", {o_ic_valid, o_dc_valid}, 2'b00);
        tick();
        arst_n    = 1'b1;
        exp_line  = '0;
        exp_rdata = '0;
        serve(1'b0, 1'b0, 1'b0, 32'h8000_0040, 8'd3, 3'd3, 8'hFF, 4, 1, 64'h5A5);
        wait_valid();

        // Contention: both clients request continuously -> D, I, D, I
        i_ic_addr = 32'h8000_2008;
        i_dc_addr = 32'h8000_3010;
        i_dc_we   = 1'b0;
        i_ic_req  = 1'b1;
        i_dc_req  = 1'b1;
        serve(1'b1, 1'b0, 1'b0, 32'h8000_3000, 8'd3, 3'd3, 8'hFF, 4, 0, 64'h1001);
        wait_valid();
        i_dc_req = 1'b1;
        // Extra fifth handshake must not disturb beats 0..3
        serve(1'b0, 1'b0, 1'b0, 32'h8000_2000, 8'd3, 3'd3, 8'hFF, 5, 0, 64'h2002);
        wait_valid();
        i_ic_req = 1'b1;
        serve(1'b1, 1'b0, 1'b0, 32'h8000_3000, 8'd3, 3'd3, 8'hFF, 4, 1, 64'h3003);
        wait_valid();
        i_dc_req = 1'b1;
        serve(1'b0, 1'b0, 1'b0, 32'h8000_2000, 8'd3, 3'd3, 8'hFF, 4, 0, 64'h4004);
        wait_valid();
        i_dc_req = 1'b0;
        check("overflow_line", o_ic_line, {64'h1_0010, 64'hC00C, 64'h8008, 64'h4004});
        tick();
        check("idle_after", {o_read_req, o_write_req, o_ic_valid, o_dc_valid}, 4'b0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
